booth_mul_arbiter: RTL and testbench

//  Shares one combinational 16x16 signed radix-4 Booth multiplier (booth_top) among NUM_REQ requesters.

---
 rtl/booth_mul_arbiter_if.sv | 29 ++
 rtl/booth_mul_arbiter.sv | 93 +++++++++
 tb/tb_booth_mul_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_arbiter_if.sv
// Bundles the requester, multiplier and result signals of booth_mul_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface booth_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) ();
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*16-1:0] req_a;
  logic [NUM_REQ*16-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [15:0]           mul_a;
  logic [15:0]           mul_b;
  logic [31:0]           mul_p;
  logic                  res_valid;
  logic [31:0]           res_data;
  logic [IDW-1:0]        res_id;
  logic                  res_ready;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, mul_p, res_ready,
    input  req_ready, mul_a, mul_b, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_p, res_ready,
    output req_ready, mul_a, mul_b, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin sharing of one external combinational Booth multiplier among
// NUM_REQ requesters, with an operand stage (S1) and a product stage (S2).
module booth_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input logic               clk,
  input logic               rst,
  booth_mul_arbiter_if.slave bus
);

  logic                s1_valid_q;
  logic [15:0]         s1_a_q;
  logic [15:0]         s1_b_q;
  logic [IDW-1:0]      s1_id_q;
  logic                s2_valid_q;
  logic [31:0]         s2_data_q;
  logic [IDW-1:0]      s2_id_q;
  logic [IDW-1:0]      rr_ptr_q;

  logic                s1_adv;
  logic                s2_adv;
  logic                any_req;
  logic                hs;
  logic [IDW-1:0]      grant;
  logic [NUM_REQ-1:0]  req_ready_d;

  assign s2_adv  = !s2_valid_q || bus.res_ready;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign any_req = |bus.req_valid;
  assign hs      = s1_adv && any_req;

  // First valid requester after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  // Held low during reset so no requester sees an accept that cannot land.
  always_comb begin
    req_ready_d = '0;
    if (hs && !rst) req_ready_d[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_id_q    <= '0;
      rr_ptr_q   <= IDW'(NUM_REQ - 1);
    end else begin
      if (hs) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= bus.req_a[16*grant +: 16];
        s1_b_q     <= bus.req_b[16*grant +: 16];
        s1_id_q    <= grant;
        rr_ptr_q   <= grant;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= bus.mul_p;
          s2_id_q   <= s1_id_q;
        end
      end
    end
  end

  assign bus.req_ready = req_ready_d;
  assign bus.mul_a     = s1_a_q;
  assign bus.mul_b     = s1_b_q;
  assign bus.res_valid = s2_valid_q;
  assign bus.res_data  = s2_data_q;
  assign bus.res_id    = s2_id_q;
  assign bus.busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter: vector table plus multi-cycle sequences,
// with a scoreboard tracking every accepted request through to the result port.
module tb_booth_mul_arbiter;

  logic clk;
  logic rst;

  booth_mul_arbiter_if #(.NUM_REQ(4), .IDW(2)) bus ();

  booth_mul_arbiter #(.NUM_REQ(4), .IDW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in for the external booth_top: signed 16x16 -> 32.
  logic signed [31:0] ext_a;
  logic signed [31:0] ext_b;
  assign ext_a     = {{16{bus.mul_a[15]}}, bus.mul_a};
  assign ext_b     = {{16{bus.mul_b[15]}}, bus.mul_b};
  assign bus.mul_p = ext_a * ext_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] p;
    logic [1:0]  id;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          id;
    logic [31:0] p;
  } vec_t;
  vec_t vt[6];

  logic [15:0] a_q[4];
  logic [15:0] b_q[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[16*i +: 16] = a_q[i];
      bus.req_b[16*i +: 16] = b_q[i];
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock; operands of accepted requesters move on so each product is distinct.
  task automatic tick();
    logic [3:0] h;
    h = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (h[i]) begin
        a_q[i] = a_q[i] + 16'h0111;
        b_q[i] = b_q[i] - 16'h0023;
      end
    end
    drive();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
    chk({tag, "_mul_a"},     32'(bus.mul_a),     32'h0);
    chk({tag, "_mul_b"},     32'(bus.mul_b),     32'h0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'h0);
    chk({tag, "_res_data"},  bus.res_data,       32'h0);
    chk({tag, "_res_id"},    32'(bus.res_id),    32'h0);
    chk({tag, "_busy"},      32'(bus.busy),      32'h0);
  endtask

  task automatic drain(input string tag);
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    repeat (4) tick();
    settle();
    chk({tag, "_busy"},      32'(bus.busy),      32'h0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'h0);
    chk({tag, "_sb_empty"},  32'(sbq.size()),    32'h0);
  endtask

  // Scoreboard and result-stability monitor, sampled late in the low phase.
  initial begin : monitor
    logic        stall_q;
    logic [31:0] hold_d;
    logic [1:0]  hold_id;
    exp_t        e;
    logic [31:0] pa;
    logic [31:0] pb;
    stall_q = 1'b0;
    hold_d  = '0;
    hold_id = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        sbq.delete();
        stall_q = 1'b0;
      end else begin
        chk("rdy_onehot", 32'($countones(bus.req_ready) <= 1), 32'h1);
        if (stall_q) begin
          chk("hold_valid", 32'(bus.res_valid), 32'h1);
          chk("hold_data",  bus.res_data,       hold_d);
          chk("hold_id",    32'(bus.res_id),    32'(hold_id));
        end
        if (bus.res_valid && bus.res_ready) begin
          chk("sb_nonempty", 32'(sbq.size() != 0), 32'h1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("sb_data", bus.res_data,    e.p);
            chk("sb_id",   32'(bus.res_id), 32'(e.id));
          end
        end
        for (int i = 0; i < 4; i++) begin
          if (bus.req_valid[i] && bus.req_ready[i]) begin
            pa = {{16{bus.req_a[16*i+15]}}, bus.req_a[16*i +: 16]};
            pb = {{16{bus.req_b[16*i+15]}}, bus.req_b[16*i +: 16]};
            e.p  = pa * pb;
            e.id = 2'(i);
            sbq.push_back(e);
          end
        end
        stall_q = bus.res_valid && !bus.res_ready;
        hold_d  = bus.res_data;
        hold_id = bus.res_id;
      end
    end
  end

  initial begin : main
    logic [3:0] oh;
    vt[0] = '{a: 16'hFFFD, b: 16'h0005, id: 0, p: 32'hFFFFFFF1};
    vt[1] = '{a: 16'h8000, b: 16'h8000, id: 2, p: 32'h40000000};
    vt[2] = '{a: 16'h7FFF, b: 16'h8000, id: 1, p: 32'hC0008000};
    vt[3] = '{a: 16'hFFFF, b: 16'hFFFF, id: 0, p: 32'h00000001};
    vt[4] = '{a: 16'h1234, b: 16'h0002, id: 2, p: 32'h00002468};
    vt[5] = '{a: 16'h7FFF, b: 16'h7FFF, id: 3, p: 32'h3FFF0001};

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_q[i] = '0;
      b_q[i] = '0;
    end
    drive();
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    @(negedge clk);
    #1;
    settle();
    chk_all_zero("reset");
    tick();
    rst = 1'b0;

    // Single transactions: latency, operand forwarding and arithmetic corners.
    for (int v = 0; v < 6; v++) begin
      oh = 4'b0001 << vt[v].id;
      a_q[vt[v].id] = vt[v].a;
      b_q[vt[v].id] = vt[v].b;
      drive();
      bus.req_valid = oh;
      bus.res_ready = 1'b1;
      settle();
      chk("vec_ready", 32'(bus.req_ready), 32'(oh));
      tick();
      bus.req_valid = '0;
      settle();
      chk("vec_lat1_valid", 32'(bus.res_valid), 32'h0);
      chk("vec_mul_a",      32'(bus.mul_a),     32'(vt[v].a));
      chk("vec_mul_b",      32'(bus.mul_b),     32'(vt[v].b));
      chk("vec_busy",       32'(bus.busy),      32'h1);
      tick();
      settle();
      chk("vec_res_valid", 32'(bus.res_valid), 32'h1);
      chk("vec_res_data",  bus.res_data,       vt[v].p);
      chk("vec_res_id",    32'(bus.res_id),    32'(vt[v].id));
      tick();
      settle();
      chk("vec_after_valid", 32'(bus.res_valid), 32'h0);
      chk("vec_after_busy",  32'(bus.busy),      32'h0);
    end

    // All requesters active: rotation 0,1,2,3,0,1 at one product per cycle.
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      settle();
      oh = 4'b0001 << (k % 4);
      chk("rr_all_grant", 32'(bus.req_ready), 32'(oh));
      if (k >= 2) begin
        chk("rr_all_res_valid", 32'(bus.res_valid), 32'h1);
        chk("rr_all_res_id",    32'(bus.res_id),    32'((k - 2) % 4));
      end
      tick();
    end
    drain("rr_all_drain");

    // Requesters 1 and 3 only, pointer left at 1: alternate 3,1,...
    bus.req_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      settle();
      oh = (k % 2 == 0) ? 4'b1000 : 4'b0010;
      chk("rr_pair_grant", 32'(bus.req_ready), 32'(oh));
      tick();
    end
    drain("rr_pair_drain");

    // Backpressure: both stages fill, result frozen, then drains in order.
    a_q[0] = 16'h0010;
    b_q[0] = 16'h0003;
    drive();
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b1;
    settle();
    tick();
    tick();
    bus.res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("bp_ready_low", 32'(bus.req_ready), 32'h0);
      chk("bp_res_valid", 32'(bus.res_valid), 32'h1);
      chk("bp_res_data",  bus.res_data,       32'h00000030);
      chk("bp_busy",      32'(bus.busy),      32'h1);
      tick();
    end
    bus.res_ready = 1'b1;
    settle();
    chk("bp_refill_ready", 32'(bus.req_ready), 32'h1);
    chk("bp_first_data",   bus.res_data,       32'h00000030);
    tick();
    settle();
    chk("bp_second_data", bus.res_data, 32'hFFFFDBE0);
    tick();
    drain("bp_drain");

    // Reset with both stages full clears everything at once.
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b0;
    settle();
    tick();
    tick();
    settle();
    chk("rst_pre_busy",  32'(bus.busy),      32'h1);
    chk("rst_pre_valid", 32'(bus.res_valid), 32'h1);
    tick();
    bus.req_valid = 4'b1111;
    rst = 1'b1;
    settle();
    chk_all_zero("midrst");
    tick();
    rst = 1'b0;
    settle();
    chk("post_rst_grant", 32'(bus.req_ready), 32'h1);
    bus.res_ready = 1'b1;
    tick();
    tick();
    tick();
    drain("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
